// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Purpose  : Shares BRAM port B between the CPU (m0) and a debug/loader
//             master (m1) with a req/gnt handshake and read-data return.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 16,
    parameter int POLICY     = 0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_din,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_din,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,

    output logic                  busy
);

    typedef logic [1:0] state_t;
    localparam state_t c_st_idle  = 2'd0;
    localparam state_t c_st_issue = 2'd1;
    localparam state_t c_st_wait  = 2'd2;
    localparam state_t c_st_resp  = 2'd3;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_win;        // 0 = m0 owns the current access, 1 = m1
    logic                  r_last_grant;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_din;
    logic [DATA_WIDTH-1:0] r_m0_rdata;
    logic [DATA_WIDTH-1:0] r_m1_rdata;

    logic                  w_any_req;
    logic                  w_pick_m1;

    assign w_any_req = m0_req | m1_req;

    // On a tie, round-robin grants the port that did not win last time.
    always_comb begin
        w_pick_m1 = m1_req;
        if (m0_req && m1_req) begin
            w_pick_m1 = (POLICY == 0) ? ~r_last_grant : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_en      = 1'b0;
        m0_gnt      = 1'b0;
        m1_gnt      = 1'b0;
        m0_rvalid   = 1'b0;
        m1_rvalid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            c_st_idle: begin
                busy = 1'b0;
                if (w_any_req) begin
                    w_state_nxt = c_st_issue;
                end
            end
            c_st_issue: begin
                mem_en      = 1'b1;
                m0_gnt      = ~r_win;
                m1_gnt      = r_win;
                w_state_nxt = r_mem_we ? c_st_idle : c_st_wait;
            end
            c_st_wait: begin
                w_state_nxt = c_st_resp;
            end
            c_st_resp: begin
                m0_rvalid   = ~r_win;
                m1_rvalid   = r_win;
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_win        <= 1'b0;
            r_last_grant <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_din    <= '0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            // mem_we is only ever high during the ISSUE cycle.
            r_mem_we <= 1'b0;
            if (r_state == c_st_idle && w_any_req) begin
                r_win        <= w_pick_m1;
                r_last_grant <= w_pick_m1;
                r_mem_we     <= w_pick_m1 ? m1_we   : m0_we;
                r_mem_addr   <= w_pick_m1 ? m1_addr : m0_addr;
                r_mem_din    <= w_pick_m1 ? m1_din  : m0_din;
            end
            if (r_state == c_st_wait) begin
                if (r_win) begin
                    r_m1_rdata <= mem_dout;
                end else begin
                    r_m0_rdata <= mem_dout;
                end
            end
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign m0_rdata = r_m0_rdata;
    assign m1_rdata = r_m1_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Purpose  : Directed bench for dmem_port_arbiter, round-robin and fixed
//             priority instances driven side by side.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [8:0]  m0_addr, m1_addr;
    logic [15:0] m0_din, m1_din;

    logic        a_m0_gnt, a_m0_rvalid, a_m1_gnt, a_m1_rvalid;
    logic [15:0] a_m0_rdata, a_m1_rdata;
    logic        a_mem_en, a_mem_we, a_busy;
    logic [8:0]  a_mem_addr;
    logic [15:0] a_mem_din, a_mem_dout;

    logic        b_m0_gnt, b_m0_rvalid, b_m1_gnt, b_m1_rvalid;
    logic [15:0] b_m0_rdata, b_m1_rdata;
    logic        b_mem_en, b_mem_we, b_busy;
    logic [8:0]  b_mem_addr;
    logic [15:0] b_mem_din, b_mem_dout;

    logic [15:0] a_ram [0:511];
    logic [15:0] b_ram [0:511];

    int checks = 0;
    int errors = 0;

    dmem_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .POLICY(0)) u_rr (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_gnt(a_m0_gnt), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_gnt(a_m1_gnt), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_din(a_mem_din), .mem_dout(a_mem_dout), .busy(a_busy)
    );

    dmem_port_arbiter #(.ADDR_WIDTH(9), .DATA_WIDTH(16), .POLICY(1)) u_fp (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_din(m0_din),
        .m0_gnt(b_m0_gnt), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_din(m1_din),
        .m1_gnt(b_m1_gnt), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_din(b_mem_din), .mem_dout(b_mem_dout), .busy(b_busy)
    );

    // Synchronous-read BRAM port models, one per instance.
    always @(posedge clk) begin
        if (a_mem_en) begin
            if (a_mem_we) a_ram[a_mem_addr] <= a_mem_din;
            else          a_mem_dout <= a_ram[a_mem_addr];
        end
        if (b_mem_en) begin
            if (b_mem_we) b_ram[b_mem_addr] <= b_mem_din;
            else          b_mem_dout <= b_ram[b_mem_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 9'h010; m0_din = 16'hBEEF;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 9'h000; m1_din = 16'h0000;

        // Reset held two cycles with m0 requesting.
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_busy",   a_busy,     0);
            chk("rst_gnt",    a_m0_gnt,   0);
            chk("rst_mem_en", a_mem_en,   0);
            chk("rst_mem_we", a_mem_we,   0);
            chk("rst_addr",   a_mem_addr, 0);
            chk("rst_rvalid", a_m0_rvalid, 0);
            chk("rst_rdata",  a_m0_rdata, 0);
        end
        rst = 1'b0;
        chk("post_rst_idle_gnt", a_m0_gnt, 0);

        // m0 write 0x010 = BEEF.
        tick();
        chk("wr_m0_gnt",   a_m0_gnt,   1);
        chk("wr_m1_gnt",   a_m1_gnt,   0);
        chk("wr_mem_en",   a_mem_en,   1);
        chk("wr_mem_we",   a_mem_we,   1);
        chk("wr_mem_addr", a_mem_addr, 9'h010);
        chk("wr_mem_din",  a_mem_din,  16'hBEEF);
        chk("wr_busy",     a_busy,     1);
        m0_req = 1'b0;
        tick();
        chk("wr_back_idle", a_busy, 0);
        chk("wr_we_clear",  a_mem_we, 0);

        // m0 read 0x010.
        m0_req = 1'b1; m0_we = 1'b0;
        tick();
        chk("rd_gnt",    a_m0_gnt, 1);
        chk("rd_mem_we", a_mem_we, 0);
        m0_req = 1'b0;
        tick();
        chk("rd_wait_en",     a_mem_en,    0);
        chk("rd_wait_rvalid", a_m0_rvalid, 0);
        chk("rd_wait_busy",   a_busy,      1);
        tick();
        chk("rd_rvalid", a_m0_rvalid, 1);
        chk("rd_rdata",  a_m0_rdata,  16'hBEEF);
        tick();
        chk("rd_rvalid_pulse", a_m0_rvalid, 0);
        chk("rd_rdata_hold",   a_m0_rdata,  16'hBEEF);
        chk("rd_idle",         a_busy,      0);

        // m1 write 0x1FF = 1234.
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 9'h1FF; m1_din = 16'h1234;
        tick();
        chk("m1wr_gnt",  a_m1_gnt,   1);
        chk("m1wr_addr", a_mem_addr, 9'h1FF);
        m1_req = 1'b0;
        tick();

        // Isolation: m1 read 0x1FF, m0 data untouched.
        m1_req = 1'b1; m1_we = 1'b0;
        tick();
        chk("iso_m1_gnt", a_m1_gnt, 1);
        chk("iso_m0_gnt", a_m0_gnt, 0);
        m1_req = 1'b0;
        tick();
        tick();
        chk("iso_m1_rvalid", a_m1_rvalid, 1);
        chk("iso_m1_rdata",  a_m1_rdata,  16'h1234);
        chk("iso_m0_rvalid", a_m0_rvalid, 0);
        chk("iso_m0_rdata",  a_m0_rdata,  16'hBEEF);
        tick();

        // Tie, both reading continuously: RR alternates, FP always m0.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 9'h1FF;
        for (int r = 0; r < 4; r++) begin
            tick();
            chk("rr_m0_gnt", a_m0_gnt, (r % 2 == 0) ? 1 : 0);
            chk("rr_m1_gnt", a_m1_gnt, (r % 2 == 1) ? 1 : 0);
            chk("fp_m0_gnt", b_m0_gnt, 1);
            chk("fp_m1_gnt", b_m1_gnt, 0);
            tick();
            tick();
            chk("rr_m0_rvalid", a_m0_rvalid, (r % 2 == 0) ? 1 : 0);
            chk("rr_m1_rvalid", a_m1_rvalid, (r % 2 == 1) ? 1 : 0);
            chk("fp_m0_rdata",  b_m0_rdata,  16'hBEEF);
            chk("fp_m1_rvalid", b_m1_rvalid, 0);
            tick();
        end
        // m0 drops: FP serves m1 on the next IDLE cycle.
        m0_req = 1'b0;
        tick();
        chk("fp_m1_served", b_m1_gnt, 1);
        chk("fp_m0_quiet",  b_m0_gnt, 0);
        m1_req = 1'b0;
        tick();
        tick();
        chk("fp_m1_rvalid", b_m1_rvalid, 1);
        chk("fp_m1_rdata",  b_m1_rdata,  16'h1234);
        tick();

        // Reset in WAIT abandons the read.
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 9'h010;
        tick();
        chk("mid_gnt", a_m0_gnt, 1);
        m0_req = 1'b0;
        tick();
        chk("mid_in_wait", a_busy, 1);
        rst = 1'b1;
        tick();
        chk("mid_busy",   a_busy,      0);
        chk("mid_rvalid", a_m0_rvalid, 0);
        chk("mid_en",     a_mem_en,    0);
        chk("mid_rdata",  a_m0_rdata,  0);
        rst = 1'b0;
        tick();
        chk("mid_no_late_rvalid", a_m0_rvalid, 0);
        m0_req = 1'b1;
        tick();
        chk("mid_re_gnt", a_m0_gnt, 1);
        m0_req = 1'b0;
        tick();
        tick();
        chk("mid_re_rvalid", a_m0_rvalid, 1);
        chk("mid_re_rdata",  a_m0_rdata,  16'hBEEF);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
